game_referee: RTL and testbench

Turn-and-outcome tracker downstream of the game manager. Samples the two 9-bit occupancy grids every clock and detects each newly placed mark. Validates that the mark belongs to the player whose turn it is, then advances the turn, move count, win/draw status and per-player win tallies. Its `gameState_gr` output drives the manager's placement gating and the display stage.

---
 rtl/game_referee.sv | 139 +++++++++++++
 tb/tb_game_referee.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/game_referee.sv
// Tic-tac-toe referee: watches both occupancy grids, validates each newly placed mark,
// and tracks turn, move count, win lines and saturating per-player win tallies.
module game_referee #(
  parameter int unsigned SCORE_W = 4
) (
  input  logic               clk_gr,
  input  logic               rst_gr,
  input  logic               newGame_gr,
  input  logic [8:0]         p1Grid_gr,
  input  logic [8:0]         p2Grid_gr,
  output logic [2:0]         gameState_gr,
  output logic [3:0]         gameIncrement_gr,
  output logic [7:0]         winLine_gr,
  output logic [SCORE_W-1:0] p1Score_gr,
  output logic [SCORE_W-1:0] p2Score_gr
);

  localparam logic [2:0] ST_P1_TURN = 3'd0;
  localparam logic [2:0] ST_P2_TURN = 3'd1;
  localparam logic [2:0] ST_P1_WIN  = 3'd2;
  localparam logic [2:0] ST_P2_WIN  = 3'd3;
  localparam logic [2:0] ST_DRAW    = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd5;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  logic [8:0]         r_p1_prev, r_p2_prev;
  logic [2:0]         r_state;
  logic [3:0]         r_count;
  logic [7:0]         r_win_line;
  logic [SCORE_W-1:0] r_p1_score, r_p2_score;

  logic [8:0]         w_p1_prev_nxt, w_p2_prev_nxt;
  logic [2:0]         w_state_nxt;
  logic [3:0]         w_count_nxt, w_count_inc;
  logic [7:0]         w_win_line_nxt, w_lines;
  logic [SCORE_W-1:0] w_p1_score_nxt, w_p2_score_nxt;
  logic [8:0]         w_add1, w_add2, w_del1, w_del2, w_mover_add, w_mover_grid;
  logic               w_change, w_in_turn, w_p1_turn, w_legal;

  // Bit 0-2 rows, 3-5 cols, 6 main diagonal, 7 anti-diagonal.
  function automatic logic [7:0] f_lines(input logic [8:0] g);
    logic [7:0] l;
    l[0] = g[0] & g[1] & g[2];
    l[1] = g[3] & g[4] & g[5];
    l[2] = g[6] & g[7] & g[8];
    l[3] = g[0] & g[3] & g[6];
    l[4] = g[1] & g[4] & g[7];
    l[5] = g[2] & g[5] & g[8];
    l[6] = g[0] & g[4] & g[8];
    l[7] = g[2] & g[4] & g[6];
    return l;
  endfunction

  always_comb begin
    w_add1 = p1Grid_gr & ~r_p1_prev;
    w_add2 = p2Grid_gr & ~r_p2_prev;
    w_del1 = r_p1_prev & ~p1Grid_gr;
    w_del2 = r_p2_prev & ~p2Grid_gr;
    w_change  = |{w_add1, w_add2, w_del1, w_del2};
    w_p1_turn = (r_state == ST_P1_TURN);
    w_in_turn = w_p1_turn || (r_state == ST_P2_TURN);

    w_mover_add  = w_p1_turn ? w_add1 : w_add2;
    w_mover_grid = w_p1_turn ? p1Grid_gr : p2Grid_gr;
    // Only the mover may add exactly one mark; nothing removed, no shared cell.
    w_legal = (w_mover_add != 9'd0) && ((w_mover_add & (w_mover_add - 9'd1)) == 9'd0)
           && ((w_p1_turn ? w_add2 : w_add1) == 9'd0)
           && (w_del1 == 9'd0) && (w_del2 == 9'd0)
           && ((p1Grid_gr & p2Grid_gr) == 9'd0);
    w_lines     = f_lines(w_mover_grid);
    w_count_inc = r_count + 4'd1;
  end

  always_comb begin
    w_p1_prev_nxt  = p1Grid_gr;
    w_p2_prev_nxt  = p2Grid_gr;
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_win_line_nxt = r_win_line;
    w_p1_score_nxt = r_p1_score;
    w_p2_score_nxt = r_p2_score;

    if (newGame_gr) begin
      w_p1_prev_nxt  = 9'd0;
      w_p2_prev_nxt  = 9'd0;
      w_state_nxt    = ST_P1_TURN;
      w_count_nxt    = 4'd0;
      w_win_line_nxt = 8'd0;
    end else if (w_change && w_in_turn) begin
      if (!w_legal) begin
        w_state_nxt = ST_FAULT;
      end else begin
        w_count_nxt = w_count_inc;
        if (w_lines != 8'd0) begin
          w_win_line_nxt = w_lines;
          if (w_p1_turn) begin
            w_state_nxt = ST_P1_WIN;
            if (r_p1_score != SCORE_MAX) w_p1_score_nxt = r_p1_score + 1'b1;
          end else begin
            w_state_nxt = ST_P2_WIN;
            if (r_p2_score != SCORE_MAX) w_p2_score_nxt = r_p2_score + 1'b1;
          end
        end else if (w_count_inc == 4'd9) begin
          w_state_nxt = ST_DRAW;
        end else begin
          w_state_nxt = w_p1_turn ? ST_P2_TURN : ST_P1_TURN;
        end
      end
    end
  end

  always_ff @(posedge clk_gr or negedge rst_gr) begin
    if (!rst_gr) begin
      r_p1_prev  <= 9'd0;
      r_p2_prev  <= 9'd0;
      r_state    <= ST_P1_TURN;
      r_count    <= 4'd0;
      r_win_line <= 8'd0;
      r_p1_score <= '0;
      r_p2_score <= '0;
    end else begin
      r_p1_prev  <= w_p1_prev_nxt;
      r_p2_prev  <= w_p2_prev_nxt;
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_win_line <= w_win_line_nxt;
      r_p1_score <= w_p1_score_nxt;
      r_p2_score <= w_p2_score_nxt;
    end
  end

  assign gameState_gr     = r_state;
  assign gameIncrement_gr = r_count;
  assign winLine_gr       = r_win_line;
  assign p1Score_gr       = r_p1_score;
  assign p2Score_gr       = r_p2_score;

endmodule

// File: tb/tb_game_referee.sv
// Directed bench for game_referee: a vector table of grid steps with expected outputs,
// plus hand sequences for asynchronous reset and score saturation.
module tb_game_referee;

  logic       clk_gr = 1'b0;
  logic       rst_gr = 1'b0;
  logic       newGame_gr = 1'b0;
  logic [8:0] p1Grid_gr = '0;
  logic [8:0] p2Grid_gr = '0;
  logic [2:0] gameState_gr;
  logic [3:0] gameIncrement_gr;
  logic [7:0] winLine_gr;
  logic [3:0] p1Score_gr;
  logic [3:0] p2Score_gr;

  int n_vec = 0;
  int n_err = 0;

  game_referee #(.SCORE_W(4)) dut (
    .clk_gr           (clk_gr),
    .rst_gr           (rst_gr),
    .newGame_gr       (newGame_gr),
    .p1Grid_gr        (p1Grid_gr),
    .p2Grid_gr        (p2Grid_gr),
    .gameState_gr     (gameState_gr),
    .gameIncrement_gr (gameIncrement_gr),
    .winLine_gr       (winLine_gr),
    .p1Score_gr       (p1Score_gr),
    .p2Score_gr       (p2Score_gr)
  );

  always #5 clk_gr = ~clk_gr;

  typedef struct {
    string      name;
    logic       ng;
    logic [8:0] p1;
    logic [8:0] p2;
    logic [2:0] st;
    logic [3:0] cnt;
    logic [7:0] wl;
    logic [3:0] s1;
    logic [3:0] s2;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic ng, input logic [8:0] p1,
                     input logic [8:0] p2, input logic [2:0] st, input logic [3:0] cnt,
                     input logic [7:0] wl, input logic [3:0] s1, input logic [3:0] s2);
    vq.push_back('{name, ng, p1, p2, st, cnt, wl, s1, s2});
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic [3:0] cnt,
                       input logic [7:0] wl, input logic [3:0] s1, input logic [3:0] s2);
    n_vec++;
    if ({gameState_gr, gameIncrement_gr, winLine_gr, p1Score_gr, p2Score_gr} !==
        {st, cnt, wl, s1, s2}) begin
      n_err++;
      $display("FAIL %s: got st=%0d cnt=%0d wl=%02h s1=%0d s2=%0d, want st=%0d cnt=%0d wl=%02h s1=%0d s2=%0d",
               name, gameState_gr, gameIncrement_gr, winLine_gr, p1Score_gr, p2Score_gr,
               st, cnt, wl, s1, s2);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next.
  task automatic drive(input logic ng, input logic [8:0] p1, input logic [8:0] p2);
    newGame_gr = ng;
    p1Grid_gr  = p1;
    p2Grid_gr  = p2;
    @(posedge clk_gr);
    #1;
  endtask

  task automatic async_reset();
    @(posedge clk_gr);
    #3;
    rst_gr = 1'b0;
    newGame_gr = 1'b0;
    p1Grid_gr = '0;
    p2Grid_gr = '0;
    #1;
  endtask

  initial begin
    // Row win by P1 (one change per 3 clocks, holds must count once).
    add("row_m1",   0, 9'h001, 9'h000, 1, 1, 8'h00, 0, 0);
    add("row_h1a",  0, 9'h001, 9'h000, 1, 1, 8'h00, 0, 0);
    add("row_h1b",  0, 9'h001, 9'h000, 1, 1, 8'h00, 0, 0);
    add("row_m2",   0, 9'h001, 9'h008, 0, 2, 8'h00, 0, 0);
    add("row_h2",   0, 9'h001, 9'h008, 0, 2, 8'h00, 0, 0);
    add("row_m3",   0, 9'h003, 9'h008, 1, 3, 8'h00, 0, 0);
    add("row_m4",   0, 9'h003, 9'h018, 0, 4, 8'h00, 0, 0);
    add("row_win",  0, 9'h007, 9'h018, 2, 5, 8'h01, 1, 0);
    add("row_stky", 0, 9'h007, 9'h01C, 2, 5, 8'h01, 1, 0);
    add("row_ng",   1, 9'h000, 9'h000, 0, 0, 8'h00, 1, 0);
    // P2 wins column 1.
    add("p2_m1",    0, 9'h001, 9'h000, 1, 1, 8'h00, 1, 0);
    add("p2_m2",    0, 9'h001, 9'h002, 0, 2, 8'h00, 1, 0);
    add("p2_m3",    0, 9'h009, 9'h002, 1, 3, 8'h00, 1, 0);
    add("p2_m4",    0, 9'h009, 9'h012, 0, 4, 8'h00, 1, 0);
    add("p2_m5",    0, 9'h109, 9'h012, 1, 5, 8'h00, 1, 0);
    add("p2_win",   0, 9'h109, 9'h092, 3, 6, 8'h10, 1, 1);
    add("p2_ng",    1, 9'h000, 9'h000, 0, 0, 8'h00, 1, 1);
    // P1 completes column 0 on move 9: win beats draw.
    add("w9_m1",    0, 9'h004, 9'h000, 1, 1, 8'h00, 1, 1);
    add("w9_m2",    0, 9'h004, 9'h002, 0, 2, 8'h00, 1, 1);
    add("w9_m3",    0, 9'h084, 9'h002, 1, 3, 8'h00, 1, 1);
    add("w9_m4",    0, 9'h084, 9'h012, 0, 4, 8'h00, 1, 1);
    add("w9_m5",    0, 9'h085, 9'h012, 1, 5, 8'h00, 1, 1);
    add("w9_m6",    0, 9'h085, 9'h032, 0, 6, 8'h00, 1, 1);
    add("w9_m7",    0, 9'h08D, 9'h032, 1, 7, 8'h00, 1, 1);
    add("w9_m8",    0, 9'h08D, 9'h132, 0, 8, 8'h00, 1, 1);
    add("w9_win",   0, 9'h0CD, 9'h132, 2, 9, 8'h08, 2, 1);
    add("w9_ng",    1, 9'h000, 9'h000, 0, 0, 8'h00, 2, 1);
    // Draw.
    add("dr_m1",    0, 9'h001, 9'h000, 1, 1, 8'h00, 2, 1);
    add("dr_m2",    0, 9'h001, 9'h010, 0, 2, 8'h00, 2, 1);
    add("dr_m3",    0, 9'h101, 9'h010, 1, 3, 8'h00, 2, 1);
    add("dr_m4",    0, 9'h101, 9'h012, 0, 4, 8'h00, 2, 1);
    add("dr_m5",    0, 9'h181, 9'h012, 1, 5, 8'h00, 2, 1);
    add("dr_m6",    0, 9'h181, 9'h052, 0, 6, 8'h00, 2, 1);
    add("dr_m7",    0, 9'h185, 9'h052, 1, 7, 8'h00, 2, 1);
    add("dr_m8",    0, 9'h185, 9'h072, 0, 8, 8'h00, 2, 1);
    add("dr_draw",  0, 9'h18D, 9'h072, 4, 9, 8'h00, 2, 1);
    add("dr_hold",  0, 9'h18D, 9'h072, 4, 9, 8'h00, 2, 1);
    add("dr_ng",    1, 9'h000, 9'h000, 0, 0, 8'h00, 2, 1);
    // Illegal moves from P1_TURN, count 0.
    add("il_wrong", 0, 9'h000, 9'h010, 5, 0, 8'h00, 2, 1);
    add("il_stky",  0, 9'h000, 9'h011, 5, 0, 8'h00, 2, 1);
    add("il_ng1",   1, 9'h000, 9'h000, 0, 0, 8'h00, 2, 1);
    add("il_two",   0, 9'h003, 9'h000, 5, 0, 8'h00, 2, 1);
    add("il_ng2",   1, 9'h000, 9'h000, 0, 0, 8'h00, 2, 1);
    add("il_ovl",   0, 9'h010, 9'h010, 5, 0, 8'h00, 2, 1);
    add("il_ng3",   1, 9'h000, 9'h000, 0, 0, 8'h00, 2, 1);
    // Mid-game newGame with a simultaneous change, then a move removal after newGame.
    add("ng_m1",    0, 9'h001, 9'h000, 1, 1, 8'h00, 2, 1);
    add("ng_chg",   1, 9'h001, 9'h008, 0, 0, 8'h00, 2, 1);
    add("ng_clr",   0, 9'h000, 9'h000, 0, 0, 8'h00, 2, 1);

    rst_gr = 1'b0;
    #12;
    check("reset", 0, 0, 8'h00, 0, 0);
    rst_gr = 1'b1;
    @(posedge clk_gr);
    #1;
    check("post_reset_idle", 0, 0, 8'h00, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].ng, vq[i].p1, vq[i].p2);
      check(vq[i].name, vq[i].st, vq[i].cnt, vq[i].wl, vq[i].s1, vq[i].s2);
    end

    // Asynchronous reset at move 4, outputs clear before the next edge.
    drive(0, 9'h001, 9'h000);
    drive(0, 9'h001, 9'h008);
    drive(0, 9'h003, 9'h008);
    drive(0, 9'h003, 9'h018);
    check("ar_move4", 0, 4, 8'h00, 2, 1);
    async_reset();
    check("ar_async", 0, 0, 8'h00, 0, 0);
    #2;
    rst_gr = 1'b1;
    drive(0, 9'h001, 9'h000);
    check("ar_resume1", 1, 1, 8'h00, 0, 0);
    drive(0, 9'h001, 9'h008);
    check("ar_resume2", 0, 2, 8'h00, 0, 0);

    // Saturation: 16 P1 wins from a fresh reset.
    async_reset();
    #2;
    rst_gr = 1'b1;
    for (int g = 1; g <= 16; g++) begin
      drive(1, 9'h000, 9'h000);
      drive(0, 9'h001, 9'h000);
      drive(0, 9'h001, 9'h008);
      drive(0, 9'h003, 9'h008);
      drive(0, 9'h003, 9'h018);
      drive(0, 9'h007, 9'h018);
      if (g >= 14) check($sformatf("sat_win%0d", g), 2, 5, 8'h01, (g > 15) ? 4'd15 : 4'(g), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
